led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: peripheral that turns captured LED commands into a timed
// LED display. Captured commands go into a 4-entry queue; a small
// IDLE/LOAD/RUN controller pops them one at a time and runs each one for its
// dwell time, measured in prescaler ticks.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   perf_en   peripheral instruction in execute
//   step      one-cycle retirement pulse of the current instruction
//   device    target device number (instr[15:11])
//   command   peripheral opcode (instr[5:0])
//   data_in   operand: [7:0] pattern, [15:8] period/duty, [23:16] dwell
//   led       registered LED drive
//   perf_bus  status word: {16'h0, busy, bad_cmd, overflow, full, empty,
//             count[2:0], led[7:0]}
module led_sequencer #(
  parameter logic [4:0] DEV_ID   = 5'd1,
  parameter int         TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        perf_en,
  input  logic        step,
  input  logic [4:0]  device,
  input  logic [5:0]  command,
  input  logic [31:0] data_in,
  output logic [7:0]  led,
  output logic [31:0] perf_bus
);

  localparam logic [5:0] OP_SET     = 6'h01;
  localparam logic [5:0] OP_BLINK   = 6'h02;
  localparam logic [5:0] OP_ROTL    = 6'h03;
  localparam logic [5:0] OP_PWM     = 6'h04;
  localparam logic [5:0] OP_CLEAR   = 6'h05;
  localparam logic [5:0] OP_STATCLR = 6'h06;

  localparam int              PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // A period field of 0 behaves like 1: the last phase index is max(P,1)-1.
  function automatic logic [7:0] period_last(input logic [7:0] p);
    return (p == 8'd0) ? 8'd0 : p - 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic [29:0] fifo_mem [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic        overflow_q, bad_cmd_q;
  logic [PRE_W-1:0] presc_q;
  logic [5:0]  op_q;
  logic [7:0]  pat_q, per_q, dwell_fld_q;
  logic [7:0]  dwell_cnt_q, phase_q;
  logic        visible_q;
  logic [3:0]  pwm_cnt_q;

  logic        capture, push, pop, push_ok, stat_clr, bad_op;
  logic        fifo_full, fifo_empty, tick;
  logic [29:0] head;

  logic unused_data;
  assign unused_data = ^data_in[31:24];

  // Capture decode
  assign capture    = perf_en && step && (device == DEV_ID);
  assign push       = capture && (command >= OP_SET) && (command <= OP_CLEAR);
  assign stat_clr   = capture && (command == OP_STATCLR);
  assign bad_op     = capture && (command > OP_STATCLR);
  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  assign pop        = (state_q == LOAD);
  // When full, a push only lands if the head leaves in the same cycle.
  assign push_ok    = push && (!fifo_full || pop);
  assign head       = fifo_mem[rd_ptr_q];
  assign tick       = (presc_q == PRE_LAST);

  // Command queue
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {command, data_in[23:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
      bad_cmd_q  <= 1'b0;
      presc_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
      if (stat_clr) begin
        overflow_q <= 1'b0;
        bad_cmd_q  <= 1'b0;
      end else begin
        if (push && !push_ok) overflow_q <= 1'b1;
        if (bad_op)           bad_cmd_q  <= 1'b1;
      end
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  // Sequencer control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if (!fifo_empty && ((dwell_fld_q == 8'd0) || (dwell_cnt_q == 8'd0)))
              state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Active command fields
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      op_q        <= head[29:24];
      dwell_fld_q <= head[23:16];
      per_q       <= head[15:8];
      pat_q       <= head[7:0];
    end else if (state_q == RUN && tick && op_q == OP_ROTL &&
                 phase_q == period_last(per_q)) begin
      pat_q <= {pat_q[6:0], pat_q[7]};
    end
  end

  // LED output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led         <= 8'd0;
      dwell_cnt_q <= 8'd0;
      phase_q     <= 8'd0;
      visible_q   <= 1'b0;
      pwm_cnt_q   <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      if (state_q == LOAD) begin
        dwell_cnt_q <= head[23:16];
        phase_q     <= 8'd0;
        visible_q   <= 1'b1;
      end else if (state_q == RUN) begin
        case (op_q)
          OP_BLINK: led <= visible_q ? pat_q : 8'd0;
          OP_PWM:   led <= (pwm_cnt_q < per_q[3:0]) ? pat_q : 8'd0;
          default:  led <= pat_q;
        endcase
        if (tick) begin
          if (dwell_cnt_q != 8'd0) dwell_cnt_q <= dwell_cnt_q - 8'd1;
          if (op_q == OP_BLINK || op_q == OP_ROTL) begin
            if (phase_q == period_last(per_q)) begin
              phase_q <= 8'd0;
              if (op_q == OP_BLINK) visible_q <= ~visible_q;
            end else begin
              phase_q <= phase_q + 8'd1;
            end
          end
        end
      end
    end
  end

  assign perf_bus = {16'h0000, (state_q != IDLE), bad_cmd_q, overflow_q,
                     fifo_full, fifo_empty, count_q, led};

endmodule
